store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered stores; power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-004 cpu_we  input  1  processor store strobe (the processor's WE).
REQ-005 cpu_addr  input  32  processor byte address (address_to_mem); used for stores and loads.
REQ-006 cpu_wdata  input  32  processor store data (data_to_mem).
REQ-007 cpu_rdata  output  32  load data returned to the processor (data_from_mem).
REQ-008 stall  output  1  store cannot be accepted this cycle; processor holds the store.
REQ-009 mem_raddr  output  32  memory asynchronous read-port address.
REQ-010 mem_rdata  input  32  memory asynchronous read-port data.
REQ-011 mem_req  output  1  write request to memory, registered.
REQ-012 mem_addr  output  32  write address, valid while mem_req.
REQ-013 mem_wdata  output  32  write data, valid while mem_req.
REQ-014 mem_ack  input  1  memory accepted the write in this cycle.
REQ-015 count  output  $clog2(DEPTH)+1  entries held, head entry included.

Function
REQ-016 Storage SHALL be a circular FIFO of DEPTH {addr, data} entries with head/tail pointers that wrap modulo DEPTH.
REQ-017 A push SHALL occur on a clock edge where cpu_we=1 and count<DEPTH; the entry is visible from the next cycle.
REQ-018 stall SHALL equal cpu_we AND count==DEPTH, combinationally; a pop in the same cycle does not clear stall (no push-at-full).
REQ-019 Drain FSM states SHALL be IDLE and REQ; IDLE->REQ when count>0, registering mem_req=1 and the head addr/data onto mem_addr/mem_wdata.
REQ-020 In REQ, mem_req, mem_addr and mem_wdata SHALL stay stable until mem_ack=1 is sampled; on that edge the head is popped and the state returns to IDLE with mem_req=0.
REQ-021 After each acknowledged write there SHALL be exactly one cycle with mem_req=0 (minimum 2 cycles per store).
REQ-022 mem_ack while in IDLE SHALL be ignored.
REQ-023 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-024 mem_raddr SHALL equal cpu_addr combinationally.
REQ-025 cpu_rdata SHALL be the data of the youngest entry with addr[31:2]==cpu_addr[31:2]; when there is no match, cpu_rdata SHALL be mem_rdata.
REQ-026 The head entry being drained SHALL remain eligible for forwarding until its pop edge.
REQ-027 A store pushed in the current cycle SHALL NOT be forwarded in that same cycle.
REQ-028 Only full-word stores SHALL be supported; addr[1:0] is stored but ignored in comparison.

Reset
REQ-029 On reset: head=tail=0, count=0, state IDLE, mem_req=0, mem_addr=0, mem_wdata=0, stall=cpu_we&0=0.
REQ-030 Reset during REQ SHALL drop mem_req immediately; the in-flight and all buffered stores are discarded.
REQ-031 Entry storage contents need not be reset; valid-ness is derived from count and pointers only.

Structure
REQ-032 A shared package SHALL hold DEPTH default, the FSM state encoding (IDLE=0, REQ=1) and the entry {addr,data} width constants.
REQ-033 Circular storage with pointers and match logic SHALL be the sub-module sb_fifo; the drain FSM and forwarding mux stay in store_buffer.

Verification
REQ-034 Single store: sw 0x100<-0xDEADBEEF, mem_ack after 2 cycles in REQ -> mem_req high 3 cycles, addr 0x100, data 0xDEADBEEF; count 1->0.
REQ-035 Fill: 5 back-to-back stores, mem_ack=0 -> count reaches 4, stall=1 on the 5th; after one ack, the 5th store is accepted next cycle.
REQ-036 Forwarding: stores 0x200<-1 then 0x200<-2 buffered, load 0x203 -> cpu_rdata=2; load 0x204 -> cpu_rdata=mem_rdata.
REQ-037 Wrap: 10 stores with mem_ack permanently 1 -> memory sees all 10 in order, pointers wrap, no loss or duplication.
REQ-038 Push+pop same edge at count=2 -> count stays 2, order preserved.
REQ-039 Reset asserted mid-REQ with 3 entries -> mem_req=0 without a clock edge, count=0, no further writes issued after deassertion.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer slice.
// Holds the default buffer depth, the drain FSM state encoding, the
// {addr,data} entry layout and a word-address compare helper.
package store_buffer_pkg;

   localparam int unsigned DEPTH_DEFAULT = 4;
   localparam int unsigned ADDR_W        = 32;
   localparam int unsigned DATA_W        = 32;
   localparam int unsigned ENTRY_W       = ADDR_W + DATA_W;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } drain_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } sb_entry_t;

   // Only full-word stores exist, so byte offset bits never take part in a match.
   function automatic logic word_match(input logic [ADDR_W-1:0] a,
                                       input logic [ADDR_W-1:0] b);
      return a[ADDR_W-1:2] == b[ADDR_W-1:2];
   endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Memory-side bus of the store buffer.
//   mem_req/mem_addr/mem_wdata/mem_ack : registered write request handshake
//   mem_raddr/mem_rdata                : asynchronous read port
// master = store buffer side, slave = memory side.
interface store_buffer_if;

   logic                               mem_req;
   logic [store_buffer_pkg::ADDR_W-1:0] mem_addr;
   logic [store_buffer_pkg::DATA_W-1:0] mem_wdata;
   logic                               mem_ack;
   logic [store_buffer_pkg::ADDR_W-1:0] mem_raddr;
   logic [store_buffer_pkg::DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_addr, mem_wdata, mem_raddr,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_addr, mem_wdata, mem_raddr,
      output mem_ack, mem_rdata
   );

endinterface

// File: rtl/store_buffer_fifo.sv
// sb_fifo: circular buffer of DEPTH {addr,data} entries plus load match logic.
//   clk, reset  : clock, asynchronous active-high reset
//   push        : write wr_entry at tail
//   pop         : retire head entry
//   head_entry  : oldest entry (meaningful while count > 0)
//   count       : number of valid entries
//   lookup_addr : load address to search for
//   hit/hit_data: youngest valid entry whose word address matches
module sb_fifo
   import store_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  sb_entry_t               wr_entry,
   input  logic                    pop,
   output sb_entry_t               head_entry,
   output logic [$clog2(DEPTH):0]  count,
   input  logic [ADDR_W-1:0]       lookup_addr,
   output logic                    hit,
   output logic [DATA_W-1:0]       hit_data
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   sb_entry_t         entries [DEPTH];
   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;
   logic [PW-1:0]     idx;

   // Entry contents carry no reset; validity comes from head and count only.
   always_ff @(posedge clk) begin
      if (push) begin
         entries[tail] <= wr_entry;
      end
   end

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head_entry = entries[head];

   // Walk oldest to youngest so the last match seen is the youngest store.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      idx      = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if ((CW'(i) < count) && word_match(entries[idx].addr, lookup_addr)) begin
            hit      = 1'b1;
            hit_data = entries[idx].data;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between processor and memory.
//   clk, reset : clock, asynchronous active-high reset
//   cpu_we     : processor store strobe
//   cpu_addr   : processor byte address (stores and loads)
//   cpu_wdata  : processor store data
//   cpu_rdata  : load data, forwarded from the youngest matching buffered store
//                or taken from the memory read port
//   stall      : store cannot be accepted this cycle
//   mem        : memory bus (write handshake + asynchronous read port)
//   count      : entries held, including the one being drained
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cpu_we,
   input  logic [ADDR_W-1:0]       cpu_addr,
   input  logic [DATA_W-1:0]       cpu_wdata,
   output logic [DATA_W-1:0]       cpu_rdata,
   output logic                    stall,
   store_buffer_if.master          mem,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   drain_state_t      state;
   sb_entry_t         wr_entry;
   sb_entry_t         head_entry;
   logic              full;
   logic              push;
   logic              pop;
   logic              hit;
   logic [DATA_W-1:0] hit_data;

   // A pop on the same edge does not free a slot for the store: no push at full.
   assign full  = (count == FULL);
   assign stall = cpu_we & full;
   assign push  = cpu_we & ~full;
   assign pop   = (state == REQ) & mem.mem_ack;

   always_comb begin
      wr_entry      = '0;
      wr_entry.addr = cpu_addr;
      wr_entry.data = cpu_wdata;
   end

   sb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (push),
      .wr_entry    (wr_entry),
      .pop         (pop),
      .head_entry  (head_entry),
      .count       (count),
      .lookup_addr (cpu_addr),
      .hit         (hit),
      .hit_data    (hit_data)
   );

   // Returning to IDLE on every ack guarantees one idle cycle between writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         mem.mem_req   <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (count != '0) begin
                  state         <= REQ;
                  mem.mem_req   <= 1'b1;
                  mem.mem_addr  <= head_entry.addr;
                  mem.mem_wdata <= head_entry.data;
               end
            end
            REQ: begin
               if (mem.mem_ack) begin
                  state       <= IDLE;
                  mem.mem_req <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               mem.mem_req <= 1'b0;
            end
         endcase
      end
   end

   assign mem.mem_raddr = cpu_addr;
   assign cpu_rdata     = hit ? hit_data : mem.mem_rdata;

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

   localparam int unsigned DEPTH = 4;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } ent_t;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   cpu_we;
   logic [31:0]            cpu_addr;
   logic [31:0]            cpu_wdata;
   logic [31:0]            cpu_rdata;
   logic                   stall;
   logic [$clog2(DEPTH):0] count;

   store_buffer_if bus ();

   int n_cmp = 0;
   int n_bad = 0;
   int ack_mode = 0;   // 0 manual, 1 always, 2 random

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
   endfunction

   assign bus.mem_rdata = mem_f(bus.mem_raddr);

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .stall     (stall),
      .mem       (bus),
      .count     (count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   ent_t q[$];          // buffered stores, oldest first
   ent_t log_q[$];      // writes the memory accepted
   bit   exp_req;
   int   m_sz;
   bit   m_push;
   bit   m_pop;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         q.delete();
         exp_req = 1'b0;
      end else begin
         m_sz   = q.size();
         m_push = cpu_we && (m_sz < DEPTH);
         m_pop  = exp_req && bus.mem_ack;
         if (m_pop) void'(q.pop_front());
         if (m_push) q.push_back('{cpu_addr, cpu_wdata});
         // a request is raised only from an idle cycle, dropped on the acked edge
         exp_req = exp_req ? !bus.mem_ack : (m_sz > 0);
      end
   end

   logic [31:0] e_rd;

   always @(negedge clk) begin
      e_rd = mem_f(cpu_addr);
      for (int i = 0; i < q.size(); i++)
         if (q[i].a[31:2] == cpu_addr[31:2]) e_rd = q[i].d;
      chk("count", 32'(count), 32'(q.size()));
      chk("stall", 32'(stall), 32'(cpu_we && (q.size() == DEPTH)));
      chk("mem_raddr", bus.mem_raddr, cpu_addr);
      chk("cpu_rdata", cpu_rdata, e_rd);
      chk("mem_req", 32'(bus.mem_req), 32'(exp_req));
      if (exp_req && q.size() > 0) begin
         chk("mem_addr", bus.mem_addr, q[0].a);
         chk("mem_wdata", bus.mem_wdata, q[0].d);
      end
      if (!reset && bus.mem_req && bus.mem_ack)
         log_q.push_back('{bus.mem_addr, bus.mem_wdata});
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      if (ack_mode == 1) bus.mem_ack = 1'b1;
      else if (ack_mode == 2) bus.mem_ack = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d);
      bit acc;
      acc = 1'b0;
      cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
      for (int k = 0; k < 40; k++) begin
         #1;
         acc = !stall;
         step();
         if (acc) break;
      end
      cpu_we = 1'b0;
      chk("push_accept", 32'(acc), 32'd1);
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      ack_mode = 1;
      for (int k = 0; k < 60; k++) begin
         if (count == 0 && !bus.mem_req) begin
            done = 1'b1;
            break;
         end
         step();
      end
      ack_mode = 0;
      bus.mem_ack = 1'b0;
      chk("drain_done", 32'(done), 32'd1);
   endtask

   task automatic chk_log(input int base, input int n, input logic [31:0] a0,
                          input logic [31:0] astep, input logic [31:0] d0);
      chk("write_count", 32'(log_q.size() - base), 32'(n));
      for (int i = 0; i < n && base + i < log_q.size(); i++) begin
         chk("write_addr", log_q[base+i].a, a0 + astep * 32'(i));
         chk("write_data", log_q[base+i].d, d0 + 32'(i));
      end
   endtask

   initial begin
      #400000;
      n_bad++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // ---------------- main sequence ----------------
   int base;
   int hi;

   initial begin
      reset = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; bus.mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_req", 32'(bus.mem_req), 32'd0);
      chk("rst_addr", bus.mem_addr, 32'd0);
      chk("rst_wdata", bus.mem_wdata, 32'd0);
      reset = 1'b0;
      step();

      // single store, acked in the third request cycle
      push(32'h100, 32'hDEAD_BEEF);
      chk("single_count1", 32'(count), 32'd1);
      hi = 0;
      for (int k = 0; k < 20; k++) begin
         bus.mem_ack = 1'b0;
         if (bus.mem_req) begin
            hi++;
            if (hi == 1) begin
               chk("single_addr", bus.mem_addr, 32'h100);
               chk("single_data", bus.mem_wdata, 32'hDEAD_BEEF);
            end
            bus.mem_ack = (hi == 3);
         end else if (hi > 0) begin
            break;
         end
         step();
      end
      bus.mem_ack = 1'b0;
      chk("single_req_cycles", 32'(hi), 32'd3);
      chk("single_count0", 32'(count), 32'd0);

      // fill to full, stall on the fifth, accepted after one ack
      base = log_q.size();
      for (int i = 0; i < 4; i++) push(32'h300 + 32'(4*i), 32'(i + 1));
      chk("fill_count4", 32'(count), 32'd4);
      chk("fill_req", 32'(bus.mem_req), 32'd1);
      cpu_we = 1'b1; cpu_addr = 32'h310; cpu_wdata = 32'd5;
      #1 chk("fill_stall", 32'(stall), 32'd1);
      step();
      chk("fill_hold", 32'(count), 32'd4);
      bus.mem_ack = 1'b1;
      #1 chk("fill_stall_at_pop", 32'(stall), 32'd1);
      step();
      bus.mem_ack = 1'b0;
      chk("fill_count3", 32'(count), 32'd3);
      #1 chk("fill_unstall", 32'(stall), 32'd0);
      step();
      cpu_we = 1'b0;
      chk("fill_count_after", 32'(count), 32'd4);
      drain();
      chk_log(base, 5, 32'h300, 32'd4, 32'd1);

      // forwarding
      push(32'h200, 32'd1);
      push(32'h200, 32'd2);
      cpu_addr = 32'h203;
      #1 chk("fwd_young", cpu_rdata, 32'd2);
      cpu_addr = 32'h204;
      #1 chk("fwd_miss", cpu_rdata, mem_f(32'h204));
      cpu_we = 1'b1; cpu_addr = 32'h200; cpu_wdata = 32'd3;
      #1 chk("fwd_not_same_cycle", cpu_rdata, 32'd2);
      step();
      cpu_we = 1'b0;
      #1 chk("fwd_new", cpu_rdata, 32'd3);
      drain();

      // wrap with ack always high
      base = log_q.size();
      ack_mode = 1;
      for (int i = 0; i < 10; i++) push(32'h400 + 32'(4*i), 32'hA0 + 32'(i));
      drain();
      chk_log(base, 10, 32'h400, 32'd4, 32'hA0);

      // push and pop on the same edge at count 2
      base = log_q.size();
      push(32'h700, 32'h11);
      push(32'h704, 32'h12);
      chk("pp_req", 32'(bus.mem_req), 32'd1);
      chk("pp_count_before", 32'(count), 32'd2);
      cpu_we = 1'b1; cpu_addr = 32'h708; cpu_wdata = 32'h13; bus.mem_ack = 1'b1;
      step();
      cpu_we = 1'b0; bus.mem_ack = 1'b0;
      chk("pp_count_after", 32'(count), 32'd2);
      drain();
      chk_log(base, 3, 32'h700, 32'd4, 32'h11);

      // reset in the middle of a request
      for (int i = 0; i < 3; i++) push(32'h600 + 32'(4*i), 32'(i));
      chk("mid_req", 32'(bus.mem_req), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_req", 32'(bus.mem_req), 32'd0);
      chk("mid_rst_count", 32'(count), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      base = log_q.size();
      ack_mode = 2;
      repeat (10) step();
      ack_mode = 0; bus.mem_ack = 1'b0;
      chk("post_rst_writes", 32'(log_q.size() - base), 32'd0);

      // random traffic against the model
      ack_mode = 2;
      for (int c = 0; c < 400; c++) begin
         if (!(cpu_we && stall)) begin
            cpu_we    = ($urandom_range(0, 2) != 0);
            cpu_addr  = 32'h500 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
            cpu_wdata = $urandom();
         end
         step();
      end
      cpu_we = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
